// File: rtl/btn_pkg.sv
// Shared constants, width helper and per-channel output bundle for the
// push-button debouncer.
package btn_pkg;

  localparam int N_BTN_DEF    = 4;
  localparam int TICK_DIV_DEF = 10000;
  localparam int DEB_MS_DEF   = 20;
  localparam int LONG_MS_DEF  = 1000;

  // Bits needed to hold any value in 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Clean outputs of one button channel.
  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic long_press;
  } btn_ch_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, tick-based stability filter,
// press/release strobes and, when BTN_LONGPRESS_EN is defined, a hold
// counter that emits a single long-press strobe per hold.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEB_MS  = DEB_MS_DEF
`ifdef BTN_LONGPRESS_EN
  , parameter int LONG_MS = LONG_MS_DEF
`endif
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_tick,
  input  logic    i_btn,
  output btn_ch_t o_ch
);

  localparam int                DCNT_W    = cnt_width(DEB_MS);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEB_MS - 1);

  logic              r_meta;
  logic              r_sync;
  logic              r_lvl;
  logic              r_press;
  logic              r_rel;
  logic [DCNT_W-1:0] r_dcnt;

  // Bring the asynchronous button into the clock domain.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
    end
  end

  // Accept a new level once it has differed from the current one for
  // DEB_MS consecutive ticks; any agreement restarts the window at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl   <= 1'b0;
      r_dcnt  <= '0;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
    end else begin
      r_press <= 1'b0;
      r_rel   <= 1'b0;
      if (r_sync == r_lvl) begin
        r_dcnt <= '0;
      end else if (i_tick) begin
        if (r_dcnt == DCNT_LAST) begin
          r_lvl   <= r_sync;
          r_dcnt  <= '0;
          r_press <= r_sync;
          r_rel   <= ~r_sync;
        end else begin
          r_dcnt <= r_dcnt + DCNT_W'(1);
        end
      end
    end
  end

  assign o_ch.level = r_lvl;
  assign o_ch.press = r_press;
  assign o_ch.rel   = r_rel;

`ifdef BTN_LONGPRESS_EN
  localparam int                HCNT_W   = cnt_width(LONG_MS);
  localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(LONG_MS);
  localparam logic [HCNT_W-1:0] HCNT_PRE = HCNT_W'(LONG_MS - 1);

  logic [HCNT_W-1:0] r_hcnt;
  logic              r_long;

  // Count ticks of a held level; saturation makes the strobe fire only once
  // per hold, and a low level re-arms it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (!r_lvl) begin
        r_hcnt <= '0;
      end else if (i_tick && (r_hcnt != HCNT_MAX)) begin
        r_hcnt <= r_hcnt + HCNT_W'(1);
        r_long <= (r_hcnt == HCNT_PRE);
      end
    end
  end

  assign o_ch.long_press = r_long;
`else
  assign o_ch.long_press = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Debouncer for N_BTN push buttons: one shared millisecond prescaler feeding
// independent per-channel filters. Define BTN_LONGPRESS_EN to build the
// long-press strobes; otherwise btn_long_o is tied low.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN    = N_BTN_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int DEB_MS   = DEB_MS_DEF,
  parameter int LONG_MS  = LONG_MS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] btn_press_o,
  output logic [N_BTN-1:0] btn_release_o,
  output logic [N_BTN-1:0] btn_long_o
);

  // Reject configurations the filter cannot implement.
  if (TICK_DIV < 2 || DEB_MS < 1 || LONG_MS < 1) begin : g_param_check
    $error("btn_debounce: need TICK_DIV>=2, DEB_MS>=1, LONG_MS>=1");
  end

  localparam int               DIV_W    = cnt_width(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             w_tick;
  btn_ch_t          w_ch [N_BTN];

  assign w_tick = (r_div == DIV_LAST);

  // Free-running prescaler shared by all channels; tick marks its last count.
  // NOTE: asynchronous active-low reset sits in the sensitivity list so state
  // clears immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEB_MS  (DEB_MS)
`ifdef BTN_LONGPRESS_EN
      , .LONG_MS (LONG_MS)
`endif
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_tick (w_tick),
      .i_btn  (btn_i[g]),
      .o_ch   (w_ch[g])
    );

    assign btn_level_o[g]   = w_ch[g].level;
    assign btn_press_o[g]   = w_ch[g].press;
    assign btn_release_o[g] = w_ch[g].rel;
    assign btn_long_o[g]    = w_ch[g].long_press;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with TICK_DIV=10, DEB_MS=4, LONG_MS=20.
// Long-press expectations follow BTN_LONGPRESS_EN.
module tb_btn_debounce;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_i = 4'h0;
  logic [3:0] btn_level_o;
  logic [3:0] btn_press_o;
  logic [3:0] btn_release_o;
  logic [3:0] btn_long_o;

  btn_debounce #(
    .N_BTN    (4),
    .TICK_DIV (10),
    .DEB_MS   (4),
    .LONG_MS  (20)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_i         (btn_i),
    .btn_level_o   (btn_level_o),
    .btn_press_o   (btn_press_o),
    .btn_release_o (btn_release_o),
    .btn_long_o    (btn_long_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_rst_rel = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  int press_cnt [4] = '{default: 0};
  int rel_cnt   [4] = '{default: 0};
  int long_cnt  [4] = '{default: 0};
  int press_cyc [4] = '{default: 0};
  int rel_cyc   [4] = '{default: 0};
  int long_cyc  [4] = '{default: 0};
  int clash_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (btn_press_o[i])   begin press_cnt[i]++; press_cyc[i] = cyc; end
        if (btn_release_o[i]) begin rel_cnt[i]++;   rel_cyc[i]   = cyc; end
        if (btn_long_o[i])    begin long_cnt[i]++;  long_cyc[i]  = cyc; end
        if (btn_press_o[i] && btn_release_o[i]) clash_cnt++;
      end
    end
  end

  // Counts at the start of the current scenario.
  int b_press [4];
  int b_rel   [4];
  int b_long  [4];

  task automatic snap();
    for (int i = 0; i < 4; i++) begin
      b_press[i] = press_cnt[i];
      b_rel[i]   = rel_cnt[i];
      b_long[i]  = long_cnt[i];
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic test_reset();
    int lat;
    btn_i = 4'hF;
    rst_n = 1'b0;
    step(3);
    total++;
    if ({btn_level_o, btn_press_o, btn_release_o, btn_long_o} !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h expected 0000",
               {btn_level_o, btn_press_o, btn_release_o, btn_long_o});
    end
    snap();
    rst_n = 1'b1;
    t_rst_rel = cyc;
    step(45);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (press_cnt[i] - b_press[i] !== 1) begin
        bad++;
        $display("FAIL reset_press_count[%0d]: got %0d expected 1", i, press_cnt[i] - b_press[i]);
      end
    end
    lat = press_cyc[0] - t_rst_rel;
    total++;
    if (lat < 31 || lat > 42) begin
      bad++;
      $display("FAIL reset_press_latency: got %0d expected 31..42", lat);
    end
    total++;
    if (press_cyc[1] !== press_cyc[0] || press_cyc[2] !== press_cyc[0] || press_cyc[3] !== press_cyc[0]) begin
      bad++;
      $display("FAIL reset_press_same_cycle: got %0d %0d %0d %0d expected all equal",
               press_cyc[0], press_cyc[1], press_cyc[2], press_cyc[3]);
    end
    total++;
    if (btn_level_o !== 4'hF) begin
      bad++;
      $display("FAIL reset_level: got %h expected f", btn_level_o);
    end
    btn_i = 4'h0;
    step(50);
    total++;
    if (btn_level_o !== 4'h0) begin
      bad++;
      $display("FAIL reset_release_level: got %h expected 0", btn_level_o);
    end
    total++;
    if ((rel_cnt[0] - b_rel[0]) + (rel_cnt[1] - b_rel[1]) + (rel_cnt[2] - b_rel[2]) + (rel_cnt[3] - b_rel[3]) !== 4) begin
      bad++;
      $display("FAIL reset_release_count: got %0d expected 4",
               (rel_cnt[0] - b_rel[0]) + (rel_cnt[1] - b_rel[1]) + (rel_cnt[2] - b_rel[2]) + (rel_cnt[3] - b_rel[3]));
    end
  endtask

  task automatic test_bounce();
    int t0;
    int lat;
    snap();
    for (int k = 0; k < 4; k++) begin
      btn_i[0] = 1'b1;
      step(15);
      btn_i[0] = 1'b0;
      step(15);
    end
    btn_i[0] = 1'b1;
    t0 = cyc;
    step(50);
    total++;
    if (press_cnt[0] - b_press[0] !== 1) begin
      bad++;
      $display("FAIL bounce_press_count: got %0d expected 1", press_cnt[0] - b_press[0]);
    end
    lat = press_cyc[0] - t0;
    total++;
    if (lat < 31 || lat > 42) begin
      bad++;
      $display("FAIL bounce_press_latency: got %0d expected 31..42", lat);
    end
    total++;
    if (rel_cnt[0] - b_rel[0] !== 0) begin
      bad++;
      $display("FAIL bounce_no_release: got %0d expected 0", rel_cnt[0] - b_rel[0]);
    end
    total++;
    if (btn_level_o !== 4'h1) begin
      bad++;
      $display("FAIL bounce_level: got %h expected 1", btn_level_o);
    end
    btn_i[0] = 1'b0;
    step(50);
  endtask

  task automatic test_glitch();
    snap();
    btn_i[1] = 1'b1;
    step(25);
    btn_i[1] = 1'b0;
    step(60);
    total++;
    if ((press_cnt[1] - b_press[1]) + (rel_cnt[1] - b_rel[1]) !== 0) begin
      bad++;
      $display("FAIL glitch_short_strobes: got %0d expected 0",
               (press_cnt[1] - b_press[1]) + (rel_cnt[1] - b_rel[1]));
    end
    total++;
    if (btn_level_o !== 4'h0) begin
      bad++;
      $display("FAIL glitch_short_level: got %h expected 0", btn_level_o);
    end
    snap();
    btn_i[1] = 1'b1;
    step(45);
    btn_i[1] = 1'b0;
    step(60);
    total++;
    if (press_cnt[1] - b_press[1] !== 1 || rel_cnt[1] - b_rel[1] !== 1) begin
      bad++;
      $display("FAIL glitch_long_strobes: got press=%0d release=%0d expected 1 and 1",
               press_cnt[1] - b_press[1], rel_cnt[1] - b_rel[1]);
    end
    total++;
    if (rel_cyc[1] <= press_cyc[1]) begin
      bad++;
      $display("FAIL glitch_long_order: got release@%0d press@%0d expected release after press",
               rel_cyc[1], press_cyc[1]);
    end
  endtask

  task automatic test_simultaneous();
    snap();
    btn_i[3:2] = 2'b11;
    step(50);
    total++;
    if (press_cnt[2] - b_press[2] !== 1 || press_cnt[3] - b_press[3] !== 1) begin
      bad++;
      $display("FAIL simul_press_count: got %0d %0d expected 1 1",
               press_cnt[2] - b_press[2], press_cnt[3] - b_press[3]);
    end
    total++;
    if (press_cyc[2] !== press_cyc[3]) begin
      bad++;
      $display("FAIL simul_same_cycle: got %0d and %0d expected equal", press_cyc[2], press_cyc[3]);
    end
    total++;
    if ((press_cnt[0] - b_press[0]) + (press_cnt[1] - b_press[1]) !== 0) begin
      bad++;
      $display("FAIL simul_quiet_low: got %0d expected 0",
               (press_cnt[0] - b_press[0]) + (press_cnt[1] - b_press[1]));
    end
    total++;
    if (btn_level_o !== 4'hC) begin
      bad++;
      $display("FAIL simul_level: got %h expected c", btn_level_o);
    end
    btn_i[3:2] = 2'b00;
    step(50);
  endtask

  task automatic test_long_press();
    int t_rel;
    int lat;
    int exp_long;
`ifdef BTN_LONGPRESS_EN
    exp_long = 1;
`else
    exp_long = 0;
`endif
    snap();
    btn_i[0] = 1'b1;
    step(300);
    btn_i[0] = 1'b0;
    t_rel = cyc;
    step(50);
    total++;
    if (long_cnt[0] - b_long[0] !== exp_long) begin
      bad++;
      $display("FAIL long_count: got %0d expected %0d", long_cnt[0] - b_long[0], exp_long);
    end
`ifdef BTN_LONGPRESS_EN
    lat = long_cyc[0] - press_cyc[0];
    total++;
    if (lat < 190 || lat > 210) begin
      bad++;
      $display("FAIL long_delay: got %0d expected 190..210", lat);
    end
`endif
    total++;
    if ((long_cnt[1] - b_long[1]) + (long_cnt[2] - b_long[2]) + (long_cnt[3] - b_long[3]) !== 0) begin
      bad++;
      $display("FAIL long_other_channels: got %0d expected 0",
               (long_cnt[1] - b_long[1]) + (long_cnt[2] - b_long[2]) + (long_cnt[3] - b_long[3]));
    end
    lat = rel_cyc[0] - t_rel;
    total++;
    if (rel_cnt[0] - b_rel[0] !== 1 || lat < 31 || lat > 42) begin
      bad++;
      $display("FAIL long_release: got count=%0d latency=%0d expected 1 and 31..42",
               rel_cnt[0] - b_rel[0], lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    snap();
    // Start the press right after a tick so dcnt is 3 thirty-five cycles on.
    while (((cyc - t_rst_rel) % 10) != 0) step(1);
    btn_i[0] = 1'b1;
    step(35);
    total++;
    if (press_cnt[0] - b_press[0] !== 0) begin
      bad++;
      $display("FAIL mid_no_early_press: got %0d expected 0", press_cnt[0] - b_press[0]);
    end
    rst_n = 1'b0;
    step(1);
    total++;
    if ({btn_level_o, btn_press_o, btn_release_o, btn_long_o} !== 16'h0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got %h expected 0000",
               {btn_level_o, btn_press_o, btn_release_o, btn_long_o});
    end
    step(4);
    rst_n = 1'b1;
    t_rst_rel = cyc;
    step(50);
    lat = press_cyc[0] - t_rst_rel;
    total++;
    if (press_cnt[0] - b_press[0] !== 1 || lat < 31 || lat > 42) begin
      bad++;
      $display("FAIL mid_fresh_window: got count=%0d latency=%0d expected 1 and 31..42",
               press_cnt[0] - b_press[0], lat);
    end
    btn_i[0] = 1'b0;
    step(50);
    total++;
    if (clash_cnt !== 0) begin
      bad++;
      $display("FAIL press_release_clash: got %0d expected 0", clash_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_long_press();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Debounces and synchronises the four raw push-button inputs (`ui_in[3:0]`) before they reach the seven-segment mode/counter logic. Each channel gets a two-flop synchroniser and a millisecond-granular stability filter. Each channel produces a clean level plus single-cycle press and release strobes for the downstream pattern logic, and optionally a long-press strobe.

## Interface
- `N_BTN`, 4, number of independent button channels
- `TICK_DIV`, 10000, clock cycles per filter tick (1 ms at 10 MHz); must be ≥2
- `DEB_MS`, 20, consecutive ticks of stable, changed input required to accept a new level; must be ≥1
- `LONG_MS`, 1000, ticks a debounced level must stay high before `btn_long_o` fires; used only with `BTN_LONGPRESS_EN`
- `clk` in 1: system clock, 10 MHz
- `rst_n` in 1: asynchronous active-low reset; all state clears immediately on assertion
- `btn_i` in N_BTN: raw, asynchronous, active-high button inputs
- `btn_level_o` out N_BTN: debounced level; reset 0
- `btn_press_o` out N_BTN: 1-cycle strobe on debounced rise; reset 0
- `btn_release_o` out N_BTN: 1-cycle strobe on debounced fall; reset 0
- `btn_long_o` out N_BTN: 1-cycle long-press strobe; reset 0

## Operation
- **Synchroniser.** Two flops per bit, both reset to 0. The second flop is `sync`.
- **Prescaler.** A shared counter runs 0..TICK_DIV-1. `tick` is high in the cycle where the count equals TICK_DIV-1. Reset value is 0.
- **Per-channel state.** Stable level `lvl` (the registered `btn_level_o`) and tick counter `dcnt` (width clog2(DEB_MS+1)).
  - **Mismatch** (`sync != lvl`): `dcnt` increments on `tick`.
  - **Match** (`sync == lvl`): `dcnt` clears to 0 in that same cycle, checked every clock, not only on ticks. Any bounce therefore restarts the window.
  - **Accept.** When a mismatch coincides with `tick` and `dcnt == DEB_MS-1`: `lvl <= sync` and `dcnt <= 0`.
- **Strobes.** Registered and written together with `lvl`. `btn_press_o` is high for exactly the first cycle `btn_level_o` reads 1; `btn_release_o` likewise for 0. Press and release are never high together on one channel.
- **Independence.** Channels are fully independent. Simultaneous strobes on several channels in one cycle are legal.
- **Long press** (only with `BTN_LONGPRESS_EN`):
  - Hold counter `hcnt` (width clog2(LONG_MS+1)) clears while `lvl == 0`.
  - It increments on `tick` while `lvl == 1` and saturates at LONG_MS.
  - `btn_long_o` pulses for one cycle on the tick that brings `hcnt` to LONG_MS. It fires once per hold, never repeats, and re-arms only after release.
  - A release after a long press still produces `btn_release_o`.
- **Reset mid-operation.** Levels, strobes and counters all go to 0. A button held through reset is seen as a fresh press and yields `btn_press_o` after one full debounce window following reset release.

## Timing
- **Synchroniser latency.** `btn_i` to `sync`: 2 cycles.
- **Filter latency.** A clean edge, stable from its arrival at `sync`, updates `btn_level_o` after between (DEB_MS-1)·TICK_DIV+1 and DEB_MS·TICK_DIV cycles. The spread is the tick phase.
- **Strobe timing.** Each strobe is asserted in the same cycle as the `btn_level_o` transition, for exactly 1 cycle.
- **Glitch rejection.**
  - Any input pulse shorter than (DEB_MS-1)·TICK_DIV cycles is always rejected.
  - Pulses of DEB_MS·TICK_DIV cycles or more are always accepted.
- **Long press.** `btn_long_o` fires LONG_MS ticks after the press strobe, within ±1 tick phase.
- No combinational path from inputs to outputs.

## Configuration
- Macro `BTN_LONGPRESS_EN`.
- **Defined.** Hold counters and long-press logic are synthesised as described.
- **Undefined.** `btn_long_o` is tied to 0. No hold counters are generated, and LONG_MS is ignored. The port list is identical in both builds.

## Structure
- **Package `btn_pkg`:**
  - default N_BTN, TICK_DIV, DEB_MS, LONG_MS constants
  - a clog2-based width helper function
  - a typedef for the per-channel strobe bundle (level/press/release/long)
- **Sub-module `btn_debounce_ch`.** One channel: synchroniser, `dcnt`, `lvl`, strobes and optional `hcnt`. The top holds the shared prescaler and a generate loop over N_BTN channels.

## Test plan
Bench parameters: TICK_DIV=10, DEB_MS=4, LONG_MS=20, `BTN_LONGPRESS_EN` defined unless noted.

- **Reset.** Assert `rst_n`=0 with `btn_i`=4'hF. All outputs read 0 during reset. After release, `btn_press_o`=4'hF pulses once within 42 cycles, and `btn_level_o` becomes 4'hF.
- **Bounce.** Toggle `btn_i[0]` with 0↔1 bursts every 15 cycles, 4 times, then hold 1. Exactly one `btn_press_o[0]` pulse occurs, 31–42 cycles after the final rising edge. No release strobe is seen.
- **Glitch.** A 25-cycle pulse on `btn_i[1]` produces no level change and no strobes. A 45-cycle pulse produces exactly one press strobe and later exactly one release strobe.
- **Simultaneous.** `btn_i[2]` and `btn_i[3]` rise in the same cycle and are held. Both `btn_press_o` bits pulse in the same cycle, and `btn_press_o[1:0]` stays 0.
- **Long press.** Hold `btn_i[0]` for 300 cycles. `btn_long_o[0]` pulses once, 200±10 cycles after the press strobe, with no repeat. The release strobe follows release within 42 cycles. With the macro undefined, `btn_long_o` stays 0.
- **Reset mid-window.** Assert `rst_n` while `dcnt[0]`=3 and the button is high. After reset release, the press appears only after a full fresh window of 31–42 cycles.
